// File: rtl/ramp_wave_gen_if.sv
// Control and sample bundle for the staircase generator: en/div/mode in, out/index/wrap back.
// No handshake; the generator samples controls every cycle and en=0 freezes it.
interface ramp_wave_gen_if #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 4,
    parameter int DIV_W = 16
);
    logic             en;
    logic [DIV_W-1:0] div;
    logic [1:0]       mode;
    logic [WIDTH-1:0] out;
    logic [IDX_W-1:0] index;
    logic             wrap;

    modport master (output en, div, mode, input out, index, wrap);
    modport slave  (input en, div, mode, output out, index, wrap);
endinterface

// File: rtl/ramp_wave_gen.sv
// Staircase generator (saw up/down, triangle, square). Step index, level and wrap update one cycle after a tick edge.
// No backpressure: en=0 holds the prescaler and waveform, and re-latches the requested mode.
module ramp_wave_gen #(
    parameter  int WIDTH = 8,
    parameter  int STEPS = 10,
    parameter  int DIV_W = 16,
    localparam int IDX_W = $clog2(STEPS)
) (
    input logic           clk,
    input logic           rst,
    ramp_wave_gen_if.slave bus
);
    typedef enum logic [1:0] {
        MODE_UP   = 2'd0,
        MODE_DOWN = 2'd1,
        MODE_TRI  = 2'd2,
        MODE_SQR  = 2'd3
    } mode_e;

    localparam logic [WIDTH-1:0] MAXV  = '1;
    localparam logic [IDX_W-1:0] KMAX  = IDX_W'(STEPS - 1);
    localparam logic [IDX_W-1:0] KHALF = IDX_W'(STEPS / 2);
    localparam logic [IDX_W-1:0] K_ONE = IDX_W'(1);
    localparam logic [DIV_W-1:0] P_ONE = DIV_W'(1);

    // Levels are elaboration-time constants; 2*WIDTH bits hold k*MAXV without overflow.
    logic [WIDTH-1:0] lut [STEPS];
    for (genvar i = 0; i < STEPS; i++) begin : g_lut
        localparam logic [2*WIDTH-1:0] NUM = (2*WIDTH)'(i) * (2*WIDTH)'(MAXV);
        localparam logic [2*WIDTH-1:0] LVL = NUM / (2*WIDTH)'(STEPS - 1);
        assign lut[i] = LVL[WIDTH-1:0];
    end

    logic [DIV_W-1:0] pcnt;
    logic [IDX_W-1:0] k;
    logic [IDX_W-1:0] k_nxt;
    logic             dir_up;
    logic             dir_nxt;
    mode_e            act_mode;
    mode_e            req_mode;
    logic             wrap_q;
    logic             tick;
    logic             boundary;

    always_comb begin
        req_mode = mode_e'(bus.mode);
        tick     = bus.en && (pcnt >= bus.div);
        k_nxt    = k;
        dir_nxt  = dir_up;
        if (act_mode == MODE_TRI) begin
            if (dir_up) begin
                k_nxt = (k == KMAX) ? k - K_ONE : k + K_ONE;
            end else begin
                k_nxt = (k == '0) ? k + K_ONE : k - K_ONE;
            end
            // Turn around on arrival so each end value is held for a single tick.
            if (k_nxt == KMAX) begin
                dir_nxt = 1'b0;
            end else if (k_nxt == '0) begin
                dir_nxt = 1'b1;
            end
        end else begin
            k_nxt = (k == KMAX) ? '0 : k + K_ONE;
        end
        boundary = tick && (k_nxt == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt     <= '0;
            k        <= '0;
            dir_up   <= 1'b1;
            act_mode <= MODE_UP;
            wrap_q   <= 1'b0;
        end else begin
            wrap_q <= boundary;
            if (bus.en) begin
                pcnt <= (pcnt >= bus.div) ? '0 : pcnt + P_ONE;
            end
            if (tick) begin
                k      <= k_nxt;
                dir_up <= dir_nxt;
            end
            if (!bus.en || boundary) begin
                act_mode <= req_mode;
                if (req_mode != act_mode) begin
                    dir_up <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        case (act_mode)
            MODE_DOWN: bus.out = lut[KMAX - k];
            MODE_SQR:  bus.out = (k < KHALF) ? '0 : MAXV;
            default:   bus.out = lut[k];
        endcase
    end

    assign bus.index = k;
    assign bus.wrap  = wrap_q;
endmodule

// File: tb/tb_ramp_wave_gen.sv
// Bench for ramp_wave_gen: vector table on the default instance plus directed prescaler, reset and small-instance sequences.
module tb_ramp_wave_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ramp_wave_gen_if #(.WIDTH(8), .IDX_W(4), .DIV_W(16)) bus_a ();
    ramp_wave_gen_if #(.WIDTH(4), .IDX_W(2), .DIV_W(16)) bus_b ();
    ramp_wave_gen_if #(.WIDTH(8), .IDX_W(1), .DIV_W(16)) bus_c ();

    ramp_wave_gen #(.WIDTH(8), .STEPS(10), .DIV_W(16)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    ramp_wave_gen #(.WIDTH(4), .STEPS(4),  .DIV_W(16)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));
    ramp_wave_gen #(.WIDTH(8), .STEPS(2),  .DIV_W(16)) dut_c (.clk(clk), .rst(rst), .bus(bus_c));

    typedef struct {
        logic        en;
        logic [15:0] div;
        logic [1:0]  mode;
        logic [7:0]  out;
        logic [3:0]  idx;
        logic        wrap;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;
    int   lvl[10]  = '{0, 28, 56, 85, 113, 141, 170, 198, 226, 255};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    task automatic add(input logic [1:0] m, input int k, input int o, input logic w);
        vec_t v;
        v.en   = 1'b1;
        v.div  = 16'd0;
        v.mode = m;
        v.out  = o[7:0];
        v.idx  = k[3:0];
        v.wrap = w;
        vecs.push_back(v);
    endtask

    task automatic tick_a();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        int hold_exp[4] = '{1, 1, 1, 2};
        int b_out[4]    = '{5, 10, 15, 0};
        int c_out[4]    = '{255, 0, 255, 0};
        int wrap_exp[4] = '{0, 0, 0, 1};
        int c_wrap[4]   = '{0, 1, 0, 1};

        bus_a.en = 1'b0; bus_a.div = '0; bus_a.mode = 2'd0;
        bus_b.en = 1'b0; bus_b.div = '0; bus_b.mode = 2'd0;
        bus_c.en = 1'b0; bus_c.div = '0; bus_c.mode = 2'd2;

        // Saw up, then saw down requested mid-period (deferred to the boundary).
        for (int k = 1; k < 10; k++) add(2'd0, k, lvl[k], 1'b0);
        add(2'd0, 0, 0, 1'b1);
        for (int k = 1; k < 10; k++) add(2'd1, k, lvl[k], 1'b0);
        add(2'd1, 0, 255, 1'b1);
        for (int k = 1; k < 10; k++) add(2'd1, k, lvl[9-k], 1'b0);
        add(2'd3, 0, 0, 1'b1);
        for (int k = 1; k < 10; k++) add(2'd3, k, (k < 5) ? 0 : 255, 1'b0);
        // Back to saw; triangle requested at k=4 only takes effect at the wrap.
        add(2'd0, 0, 0, 1'b1);
        for (int k = 1; k < 5; k++) add(2'd0, k, lvl[k], 1'b0);
        for (int k = 5; k < 10; k++) add(2'd2, k, lvl[k], 1'b0);
        add(2'd2, 0, 0, 1'b1);
        for (int k = 1; k < 10; k++) add(2'd2, k, lvl[k], 1'b0);
        for (int k = 8; k > 0; k--) add(2'd2, k, lvl[k], 1'b0);
        add(2'd2, 0, 0, 1'b1);
        add(2'd2, 1, 28, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        check("reset_out", bus_a.out, 0);
        check("reset_index", bus_a.index, 0);
        check("reset_wrap", bus_a.wrap, 0);
        #3 rst = 1'b0;

        foreach (vecs[i]) begin
            bus_a.en   = vecs[i].en;
            bus_a.div  = vecs[i].div;
            bus_a.mode = vecs[i].mode;
            tick_a();
            check($sformatf("vec%0d_out", i), bus_a.out, vecs[i].out);
            check($sformatf("vec%0d_index", i), bus_a.index, vecs[i].idx);
            check($sformatf("vec%0d_wrap", i), bus_a.wrap, vecs[i].wrap);
        end

        // Asynchronous reset in the middle of a running saw.
        rst = 1'b1;
        @(posedge clk);
        #3;
        bus_a.en = 1'b1; bus_a.div = '0; bus_a.mode = 2'd0;
        rst = 1'b0;
        repeat (6) tick_a();
        check("pre_rst_index", bus_a.index, 6);
        check("pre_rst_out", bus_a.out, 170);
        #1 rst = 1'b1;
        #1;
        check("arst_out", bus_a.out, 0);
        check("arst_index", bus_a.index, 0);
        check("arst_wrap", bus_a.wrap, 0);
        #1 rst = 1'b0;
        tick_a();
        check("post_rst_index", bus_a.index, 1);
        check("post_rst_out", bus_a.out, 28);
        check("post_rst_wrap", bus_a.wrap, 0);

        // div=3: four cycles per level, en low freezes and resumes the count.
        bus_a.div = 16'd3;
        for (int i = 0; i < 4; i++) begin
            tick_a();
            check($sformatf("hold%0d_index", i), bus_a.index, hold_exp[i]);
        end
        repeat (2) tick_a();
        check("pause_pre_index", bus_a.index, 2);
        bus_a.en = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick_a();
            check($sformatf("pause%0d_out", i), bus_a.out, 56);
            check($sformatf("pause%0d_index", i), bus_a.index, 2);
        end
        bus_a.en = 1'b1;
        tick_a();
        check("resume_hold_index", bus_a.index, 2);
        tick_a();
        check("resume_tick_index", bus_a.index, 3);
        check("resume_tick_out", bus_a.out, 85);

        // Divisor lowered below the running count ticks on the next enabled cycle.
        bus_a.div = 16'd9;
        repeat (5) tick_a();
        check("div9_hold_index", bus_a.index, 3);
        bus_a.div = 16'd2;
        tick_a();
        check("div_drop_index", bus_a.index, 4);
        check("div_drop_out", bus_a.out, 113);
        repeat (3) tick_a();
        check("div2_period_index", bus_a.index, 5);

        // Small instances: WIDTH=4/STEPS=4 saw, WIDTH=8/STEPS=2 triangle.
        bus_b.en = 1'b1;
        bus_c.en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick_a();
            check($sformatf("w4s4_out%0d", i), bus_b.out, b_out[i]);
            check($sformatf("w4s4_wrap%0d", i), bus_b.wrap, wrap_exp[i]);
            check($sformatf("s2tri_out%0d", i), bus_c.out, c_out[i]);
            check($sformatf("s2tri_wrap%0d", i), bus_c.wrap, c_wrap[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
